music_sequencer: RTL and testbench

//  Upstream stage of the tone generator (scale/playTime/finish interface). Steps through a

---
 rtl/music_sequencer_pkg.sv | 37 +++
 rtl/music_sequencer_if.sv | 29 ++
 rtl/music_sequencer_song_rom.sv | 46 ++++
 rtl/music_sequencer.sv | 170 +++++++++++++++++
 tb/tb_music_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the music sequencer: note word layout,
// END marker, scale codes and FSM state encoding.
package music_sequencer_pkg;

    localparam int NOTE_W  = 16;
    localparam int SCALE_W = 5;
    localparam int TIME_W  = 11;

    // A note word is {scale, time}; time == 0 marks the end of the song.
    localparam logic [NOTE_W-1:0] END_NOTE = '0;

    localparam logic [SCALE_W-1:0] REST = 5'd0;
    localparam logic [SCALE_W-1:0] L1 = 5'd1,  L2 = 5'd2,  L3 = 5'd3,  L4 = 5'd4;
    localparam logic [SCALE_W-1:0] L5 = 5'd5,  L6 = 5'd6,  L7 = 5'd7;
    localparam logic [SCALE_W-1:0] M1 = 5'd8,  M2 = 5'd9,  M3 = 5'd10, M4 = 5'd11;
    localparam logic [SCALE_W-1:0] M5 = 5'd12, M6 = 5'd13, M7 = 5'd14;
    localparam logic [SCALE_W-1:0] H1 = 5'd15, H2 = 5'd16, H3 = 5'd17, H4 = 5'd18;
    localparam logic [SCALE_W-1:0] H5 = 5'd19, H6 = 5'd20, H7 = 5'd21;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    function automatic logic [NOTE_W-1:0] mk_note(input logic [SCALE_W-1:0] scale,
                                                  input logic [TIME_W-1:0]  ms);
        return {scale, ms};
    endfunction

    function automatic logic is_end(input logic [NOTE_W-1:0] note);
        return (note[TIME_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control and note bus between the sequencer and its environment
// (start/stop/loop controls, tone generator enable/scale/time/finish).
interface music_sequencer_if #(
    parameter int ADDR_W = 6
);
    import music_sequencer_pkg::*;

    logic               start;
    logic               stop;
    logic               loop;
    logic               note_finish;
    logic               note_en;
    logic [SCALE_W-1:0] note_scale;
    logic [TIME_W-1:0]  note_time;
    logic [ADDR_W-1:0]  note_idx;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, loop, note_finish,
        input  note_en, note_scale, note_time, note_idx, busy, done
    );

    modport slave (
        input  start, stop, loop, note_finish,
        output note_en, note_scale, note_time, note_idx, busy, done
    );

endinterface

// File: rtl/music_sequencer_song_rom.sv
// Synchronous song table ROM (one clock read latency). SONG_ID selects
// which built-in table is compiled in; swapping songs only touches this file.
module music_sequencer_song_rom
    import music_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int SONG_ID = 0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NOTE_W-1:0] data_o
);

    logic [NOTE_W-1:0] data_d;
    logic [NOTE_W-1:0] data_q;

    // Table lookup; unlisted entries read as END.
    always_comb begin
        data_d = END_NOTE;
        if (SONG_ID == 0) begin
            case (int'(addr_i))
                0:       data_d = mk_note(M1,   11'd5);
                1:       data_d = mk_note(REST, 11'd3);
                2:       data_d = mk_note(M3,   11'd2);
                default: data_d = END_NOTE;
            endcase
        end else if (SONG_ID == 1) begin
            case (int'(addr_i))
                0:       data_d = mk_note(L1, 11'd2);
                1:       data_d = mk_note(L3, 11'd1);
                2:       data_d = mk_note(L5, 11'd3);
                3:       data_d = mk_note(H1, 11'd1);
                4:       data_d = mk_note(M2, 11'd4);
                default: data_d = END_NOTE;
            endcase
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/music_sequencer.sv
// Music sequencer: walks the song ROM, presents one note at a time to the
// tone generator, holds enable until the synchronized finish flag arrives,
// then inserts a fixed articulation gap before the next note.
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int GAP_CYCLES = 20000,
    parameter int SONG_LAST  = 63,
    parameter int SONG_ID    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    music_sequencer_if.slave bus
);

    localparam int                GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SONG_LAST);

    state_e             state_q, state_d;
    logic               sync1_q, fin_s_q;
    logic [1:0]         play_cnt_q, play_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               note_en_q, note_en_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NOTE_W-1:0]  rom_data;

    // The ROM is addressed with the next index so the entry is ready during LOAD.
    music_sequencer_song_rom #(
        .ADDR_W  (ADDR_W),
        .SONG_ID (SONG_ID)
    ) u_rom (
        .clk    (clk),
        .addr_i (idx_d),
        .data_o (rom_data)
    );

    // Two-flop synchronizer for the tone generator's finish flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            fin_s_q <= 1'b0;
        end else begin
            sync1_q <= bus.note_finish;
            fin_s_q <= sync1_q;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        play_cnt_d = play_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        note_en_d  = note_en_q;
        scale_d    = scale_q;
        time_d     = time_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q != ST_IDLE && bus.stop) begin
            state_d    = ST_IDLE;
            note_en_d  = 1'b0;
            scale_d    = '0;
            time_d     = '0;
            busy_d     = 1'b0;
            play_cnt_d = '0;
            gap_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (is_end(rom_data)) begin
                        state_d = ST_FINISH;
                    end else begin
                        scale_d    = rom_data[NOTE_W-1:TIME_W];
                        time_d     = rom_data[TIME_W-1:0];
                        note_en_d  = 1'b1;
                        play_cnt_d = '0;
                        state_d    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // The first three PLAY cycles may still see the previous note's finish.
                    if (play_cnt_q != 2'd3) begin
                        play_cnt_d = play_cnt_q + 2'd1;
                    end else if (fin_s_q) begin
                        note_en_d = 1'b0;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP plus the following LOAD/FINISH cycle give GAP_CYCLES low cycles.
                    if (gap_cnt_q > GAP_W'(1)) begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end else begin
                        gap_cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_FINISH;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_FINISH: begin
                    if (bus.loop) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        done_d    = 1'b1;
                        note_en_d = 1'b0;
                        scale_d   = '0;
                        time_d    = '0;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            play_cnt_q <= '0;
            gap_cnt_q  <= '0;
            note_en_q  <= 1'b0;
            scale_q    <= '0;
            time_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            play_cnt_q <= play_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            note_en_q  <= note_en_d;
            scale_q    <= scale_d;
            time_q     <= time_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.note_en    = note_en_q;
    assign bus.note_scale = scale_q;
    assign bus.note_time  = time_q;
    assign bus.note_idx   = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: three instances (demo song, song without END
// marker and SONG_LAST=3, song that is empty), each with a tone generator
// model raising finish after time*10 enabled cycles.
module tb_music_sequencer;

    localparam int GAP = 4;
    localparam int LIM = 600;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        st[3], sp[3], lp[3];
    logic        en_a[3], busy_a[3], done_a[3];
    logic [4:0]  scale_a[3];
    logic [10:0] time_a[3];
    logic [5:0]  idx_a[3];
    int          dcnt_a[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int tcnt = 0;
        int done_cnt = 0;

        music_sequencer_if #(.ADDR_W(6)) bus ();

        music_sequencer #(
            .ADDR_W     (6),
            .GAP_CYCLES (GAP),
            .SONG_LAST  ((g == 1) ? 3 : 63),
            .SONG_ID    (g)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.start  = st[g];
        assign bus.stop   = sp[g];
        assign bus.loop   = lp[g];
        assign en_a[g]    = bus.note_en;
        assign busy_a[g]  = bus.busy;
        assign done_a[g]  = bus.done;
        assign scale_a[g] = bus.note_scale;
        assign time_a[g]  = bus.note_time;
        assign idx_a[g]   = bus.note_idx;
        assign dcnt_a[g]  = done_cnt;

        // tone generator: finish after time*10 cycles of enable, cleared by enable low
        always @(posedge clk) begin
            if (bus.note_en !== 1'b1) begin
                tcnt            <= 0;
                bus.note_finish <= 1'b0;
            end else begin
                tcnt <= tcnt + 1;
                if (tcnt + 1 >= 10 * int'(bus.note_time)) bus.note_finish <= 1'b1;
            end
        end

        always @(posedge clk) begin
            if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    logic [1:0]  sel;
    logic        m_en, m_busy, m_done;
    logic [4:0]  m_scale;
    logic [10:0] m_time;
    logic [5:0]  m_idx;

    always_comb begin
        m_en    = en_a[sel];
        m_busy  = busy_a[sel];
        m_done  = done_a[sel];
        m_scale = scale_a[sel];
        m_time  = time_a[sel];
        m_idx   = idx_a[sel];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Song tables as written in the song book.
    function automatic void song_entry(input int s, input int i, output int sc, output int tm);
        sc = 0;
        tm = 0;
        if (s == 0) begin
            case (i)
                0: begin sc = 8;  tm = 5; end
                1: begin sc = 0;  tm = 3; end
                2: begin sc = 10; tm = 2; end
                default: ;
            endcase
        end else if (s == 1) begin
            case (i)
                0: begin sc = 1;  tm = 2; end
                1: begin sc = 3;  tm = 1; end
                2: begin sc = 5;  tm = 3; end
                3: begin sc = 15; tm = 1; end
                4: begin sc = 9;  tm = 4; end
                default: ;
            endcase
        end
    endfunction

    int exp_q[$];
    bit exp_marker;

    // Notes that a pass plays: stop at an END entry or after the last index.
    function automatic void build_expected(input int s, input int last);
        int sc, tm;
        exp_q.delete();
        exp_marker = 1'b0;
        for (int i = 0; i <= last; i++) begin
            song_entry(s, i, sc, tm);
            if (tm == 0) begin
                exp_marker = 1'b1;
                break;
            end
            exp_q.push_back(i);
        end
    endfunction

    task automatic pulse_start();
        st[sel] = 1'b1;
        @(negedge clk);
        st[sel] = 1'b0;
    endtask

    // Count samples while note_en equals want; optionally pulse start at sample poke_at.
    task automatic count_while(input logic want, input int poke_at, output int n);
        n = 0;
        while (m_en === want && n < LIM) begin
            st[sel] = (n == poke_at);
            n++;
            @(negedge clk);
        end
        st[sel] = 1'b0;
    endtask

    task automatic wait_done(output int n, output int en_seen);
        n = 0;
        en_seen = 0;
        while (m_done !== 1'b1 && n < LIM) begin
            if (m_en === 1'b1) en_seen = 1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_song(input int s, input int passes, input bit poke_start);
        int n, d0, sc, tm, last, en_seen, poke;
        sel  = s[1:0];
        last = (s == 1) ? 3 : 63;
        build_expected(s, last);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        lp[sel] = (passes > 1);
        d0 = dcnt_a[sel];
        pulse_start();
        count_while(1'b0, -1, n);
        chk("start_lat", n, 1);
        for (int p = 0; p < passes; p++) begin
            if (p == passes - 1) lp[sel] = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                song_entry(s, exp_q[k], sc, tm);
                poke = (poke_start && p == 0 && k == 1) ? int'($urandom_range(1, tm * 10)) : -1;
                chk("idx", int'(m_idx), exp_q[k]);
                chk("scale", int'(m_scale), sc);
                chk("time", int'(m_time), tm);
                count_while(1'b1, poke, n);
                chk("play_len", n, tm * 10 + 3);
                if (k < exp_q.size() - 1) begin
                    count_while(1'b0, -1, n);
                    chk("gap_len", n, GAP);
                end else if (p < passes - 1) begin
                    count_while(1'b0, -1, n);
                    chk("loop_gap", n, GAP + 1 + int'(exp_marker));
                    chk("loop_nodone", dcnt_a[sel] - d0, 0);
                end
            end
        end
        wait_done(n, en_seen);
        chk("end_lat", n, GAP + int'(exp_marker));
        chk("busy_at_done", int'(m_busy), 0);
        chk("scale_clr", int'(m_scale), 0);
        chk("time_clr", int'(m_time), 0);
        @(negedge clk);
        chk("done_pulse", int'(m_done), 0);
        chk("done_count", dcnt_a[sel] - d0, 1);
    endtask

    initial begin
        int n, d0, en_seen;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            sp[i] = 1'b0;
            lp[i] = 1'b0;
        end
        sel   = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_en", int'(m_en), 0);
        chk("rst_scale", int'(m_scale), 0);
        chk("rst_time", int'(m_time), 0);
        chk("rst_idx", int'(m_idx), 0);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // plain song, looped song, then song with start pulsed during a note
        run_song(0, 1, 1'b0);
        run_song(0, 2, 1'b0);

        // stop during note 1
        sel = 2'd0;
        d0  = dcnt_a[0];
        pulse_start();
        count_while(1'b0, -1, n);
        chk("stop_start_lat", n, 1);
        count_while(1'b1, -1, n);
        count_while(1'b0, -1, n);
        chk("stop_idx", int'(m_idx), 1);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        sp[0] = 1'b1;
        @(negedge clk);
        sp[0] = 1'b0;
        chk("stop_en", int'(m_en), 0);
        chk("stop_scale", int'(m_scale), 0);
        chk("stop_time", int'(m_time), 0);
        chk("stop_busy", int'(m_busy), 0);
        chk("stop_done", int'(m_done), 0);
        repeat (3 * GAP) @(negedge clk);
        chk("stop_idle_en", int'(m_en), 0);
        chk("stop_nodone", dcnt_a[0] - d0, 0);
        run_song(0, 1, 1'b0);
        run_song(0, 1, 1'b1);

        // start and stop together while idle
        sel = 2'd0;
        st[0] = 1'b1;
        sp[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        sp[0] = 1'b0;
        chk("ss_busy", int'(m_busy), 0);
        repeat (3) @(negedge clk);
        chk("ss_en", int'(m_en), 0);
        chk("ss_busy_later", int'(m_busy), 0);

        // reset in the middle of a note
        pulse_start();
        count_while(1'b0, -1, n);
        repeat ($urandom_range(0, 30)) @(negedge clk);
        chk("pre_rst_en", int'(m_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", int'(m_en), 0);
        chk("mid_rst_scale", int'(m_scale), 0);
        chk("mid_rst_time", int'(m_time), 0);
        chk("mid_rst_idx", int'(m_idx), 0);
        chk("mid_rst_busy", int'(m_busy), 0);
        chk("mid_rst_done", int'(m_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(m_busy), 0);
        run_song(0, 1, 1'b0);

        // table without END marker, limited by SONG_LAST=3
        run_song(1, 1, 1'b0);

        // END marker at entry 0: LOAD, FINISH, then done
        sel = 2'd2;
        d0  = dcnt_a[2];
        pulse_start();
        wait_done(n, en_seen);
        chk("empty_lat", n, 2);
        chk("empty_en", en_seen, 0);
        chk("empty_busy", int'(m_busy), 0);
        @(negedge clk);
        chk("empty_done_count", dcnt_a[2] - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
